fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction fetch controller that drives the program counter update interface from the consumer side. Takes the current `PC`, fetches one 16-bit instruction from instruction memory over a req/ready handshake, and presents it to decode over a valid/ack handshake. After acceptance it issues exactly one `updatePC` pulse, with `jump`/`offset` pre-decoded from the instruction. It sits between the PC register, instruction memory and the decode stage.

## Interface
Parameters:
- `JMP_OP`, 4'hC: opcode in `instr[15:12]` for an unconditional relative jump.
- `BR_OP`, 4'hD: opcode for a conditional relative branch.
- `HLT_OP`, 4'hF: halt opcode; only used when `HALT_DETECT_EN` is defined.

Ports:
- `Clk2`, input, 1: the only clock; all state updates on posedge.
- `reset`, input, 1: asynchronous, active-high.
- `PC`, input, 16: current program counter.
- `mem_addr`, output, 16: instruction memory address.
- `mem_req`, output, 1: fetch request.
- `mem_ready`, input, 1: memory has `mem_rdata` valid this cycle.
- `mem_rdata`, input, 16: fetched instruction word.
- `instr`, output, 16: instruction register contents.
- `instr_valid`, output, 1: `instr` is valid for decode.
- `instr_ack`, input, 1: decode accepts `instr`.
- `cond`, input, 1: branch condition from execute, sampled in UPD.
- `updatePC`, output, 1: one-cycle PC update strobe.
- `jump`, output, 1: select PC+offset (1) or PC+1 (0).
- `offset`, output, 12: two's-complement word offset (`instr[11:0]`).
- `halted`, output, 1: controller is in HALT.

## Operation
- States: IDLE, REQ, HOLD, UPD, HALT.
- IDLE: entered on reset. Goes to REQ on the first clock edge after `reset` deasserts.
- REQ: `mem_req`=1 and `mem_addr`=`PC`, both combinational from state.
  - On `mem_ready`=1: capture `mem_rdata` into `instr` and go to HOLD.
  - Otherwise stay in REQ; there is no timeout.
- HOLD: `instr_valid`=1 and `instr` is stable.
  - On `instr_ack`=1: go to UPD. With `HALT_DETECT_EN` and opcode equal to `HLT_OP`, go to HALT instead.
- UPD: `updatePC`=1 for exactly one cycle, then go to REQ.
  - `jump`=1 if opcode is `JMP_OP`, or if opcode is `BR_OP` and `cond`=1. Otherwise `jump`=0.
  - `offset`=`instr[11:0]` when `jump`=1, else 12'h000.
  - The PC register extends `offset` to 16 bits, adds it and wraps modulo 2^16. `fetch_ctrl` does no arithmetic on `PC`.
- HALT: all strobes are 0 and `halted`=1. Only `reset` exits HALT.
- `updatePC`, `jump` and `offset` are 0 in every state except UPD.

## Timing
- Reset values, applied immediately on `reset` assertion: state=IDLE, `instr`=16'h0000, and `mem_req`, `instr_valid`, `updatePC`, `jump`, `halted` all 0, `offset`=0.
- Reset mid-fetch or mid-hold: the pending request or instruction is dropped with no `updatePC`, and fetch restarts at `PC` (which the PC register has also reset to 0).
- Minimum loop is 3 cycles per instruction (REQ, HOLD, UPD), reached when `mem_ready` and `instr_ack` are each 1 on their first cycle.
- `mem_ready` is ignored outside REQ; `instr_ack` is ignored outside HOLD.
- `PC` changes at the UPD edge. REQ in the next cycle therefore sees the new `PC`; no stale address is ever issued.
- `cond` is sampled only in the UPD cycle. Changes to it in HOLD have no effect.
- Offset 12'h800 (-2048) from `PC`=16'h0000 wraps to 16'hF800 in the PC register; this is legal.

## Configuration
- `HALT_DETECT_EN` defined: `HLT_OP` acknowledged in HOLD goes to HALT, issues no `updatePC`, and `halted`=1.
- `HALT_DETECT_EN` undefined: `HLT_OP` is an ordinary non-jump instruction (PC+1), the HALT state is not compiled, and `halted` is tied to 0.

## Structure
- Shared package `fetch_pkg`: state encoding (3-bit), opcode constants `JMP_OP`/`BR_OP`/`HLT_OP`, and the `OPC_MSB`/`OPC_LSB` field positions.
- One sub-module, `fetch_predecode`: combinational. Takes `instr` and `cond`; produces `is_jump`, `is_halt` and the 12-bit offset. The FSM and the instruction register stay in `fetch_ctrl`.

## Test plan
- Reset release with `PC`=0, memory returns 16'h1234 with zero wait, `instr_ack` held 1 -> `mem_req` in cycle 1, `instr_valid` in cycle 2, `updatePC`=1 with `jump`=0 and `offset`=0 in cycle 3.
- `instr`=16'hC005 -> `updatePC`=1, `jump`=1, `offset`=12'h005. `instr`=16'hCFFE -> `offset`=12'hFFE, and the next `mem_addr` equals PC-2.
- `instr`=16'hD010 with `cond`=0 in UPD -> `jump`=0. The same instruction with `cond`=1 -> `jump`=1 and `offset`=12'h010.
- `mem_ready` delayed 4 cycles and `instr_ack` delayed 3 cycles -> `mem_req` held 4 cycles, `instr` stable for 3 cycles, exactly one `updatePC`.
- `reset` asserted during HOLD -> outputs are 0 the same cycle, no `updatePC` follows, and fetch restarts at 16'h0000.
- With `HALT_DETECT_EN`, `instr`=16'hF000 acked -> `halted`=1 and no further `mem_req`. Without it -> `updatePC`=1, `jump`=0 and fetch continues.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch controller:
//   - state_t   : 3-bit FSM state encoding
//   - JMP_OP / BR_OP / HLT_OP : default opcode values in instr[15:12]
//   - OPC_MSB / OPC_LSB       : opcode field position
//   - OFF_W                   : width of the relative word offset field
//   - opcode_of()             : extracts the opcode field from an instruction
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_HOLD = 3'd2,
    ST_UPD  = 3'd3,
    ST_HALT = 3'd4
  } state_t;

  localparam logic [3:0] JMP_OP = 4'hC;
  localparam logic [3:0] BR_OP  = 4'hD;
  localparam logic [3:0] HLT_OP = 4'hF;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int OFF_W   = 12;

  function automatic logic [3:0] opcode_of(input logic [15:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// -----------------------------------------------------------------------------
// fetch_predecode
// Combinational pre-decode of the instruction register for the PC update.
// Ports:
//   i_instr   [15:0]  instruction register contents
//   i_cond            branch condition from execute
//   o_is_jump         relative jump taken (JMP, or BR with i_cond=1)
//   o_is_halt         opcode is the halt opcode
//   o_offset  [11:0]  instr[11:0] when the jump is taken, else zero
// -----------------------------------------------------------------------------
module fetch_predecode #(
  parameter logic [3:0] JMP_OP = fetch_pkg::JMP_OP,
  parameter logic [3:0] BR_OP  = fetch_pkg::BR_OP,
  parameter logic [3:0] HLT_OP = fetch_pkg::HLT_OP
) (
  input  logic [15:0] i_instr,
  input  logic        i_cond,
  output logic        o_is_jump,
  output logic        o_is_halt,
  output logic [11:0] o_offset
);
  import fetch_pkg::*;

  logic [3:0] w_opc;

  assign w_opc     = opcode_of(i_instr);
  assign o_is_jump = (w_opc == JMP_OP) || ((w_opc == BR_OP) && i_cond);
  assign o_is_halt = (w_opc == HLT_OP);
  assign o_offset  = o_is_jump ? i_instr[OFF_W-1:0] : '0;

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction fetch controller: fetches one word at PC over a req/ready
// handshake, holds it for decode over a valid/ack handshake, then issues one
// updatePC strobe with pre-decoded jump/offset for the PC register.
// Build option: HALT_DETECT_EN - when defined, an acked HLT_OP instruction
// parks the controller in HALT (halted=1) until reset; otherwise HLT_OP is an
// ordinary PC+1 instruction and halted is tied to 0.
// Ports:
//   Clk2               clock, posedge
//   reset              asynchronous, active-high
//   PC        [15:0]   current program counter
//   mem_addr  [15:0]   instruction memory address (PC while requesting)
//   mem_req            fetch request
//   mem_ready          mem_rdata valid this cycle
//   mem_rdata [15:0]   fetched instruction word
//   instr     [15:0]   instruction register
//   instr_valid        instr valid for decode
//   instr_ack          decode accepts instr
//   cond               branch condition, used only in the update cycle
//   updatePC           one-cycle PC update strobe
//   jump               1: PC+offset, 0: PC+1
//   offset    [11:0]   two's-complement word offset
//   halted             controller is halted
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [3:0] JMP_OP = fetch_pkg::JMP_OP,
  parameter logic [3:0] BR_OP  = fetch_pkg::BR_OP,
  parameter logic [3:0] HLT_OP = fetch_pkg::HLT_OP
) (
  input  logic        Clk2,
  input  logic        reset,
  input  logic [15:0] PC,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        cond,
  output logic        updatePC,
  output logic        jump,
  output logic [11:0] offset,
  output logic        halted
);
  import fetch_pkg::*;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_instr;
  logic        w_is_jump;
  logic        w_is_halt;
  logic [11:0] w_offset;

  fetch_predecode #(
    .JMP_OP (JMP_OP),
    .BR_OP  (BR_OP),
    .HLT_OP (HLT_OP)
  ) u_predecode (
    .i_instr   (r_instr),
    .i_cond    (cond),
    .o_is_jump (w_is_jump),
    .o_is_halt (w_is_halt),
    .o_offset  (w_offset)
  );

`ifndef HALT_DETECT_EN
  logic w_unused_halt;
  assign w_unused_halt = w_is_halt;
`endif

  always_ff @(posedge Clk2 or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // The register only loads in REQ, so mem_ready/mem_rdata outside REQ
  // can never disturb the word decode is looking at.
  always_ff @(posedge Clk2 or posedge reset) begin
    if (reset)                                r_instr <= 16'h0000;
    else if ((r_state == ST_REQ) && mem_ready) r_instr <= mem_rdata;
  end

  assign instr = r_instr;

  always_comb begin
    w_next      = r_state;
    mem_req     = 1'b0;
    mem_addr    = 16'h0000;
    instr_valid = 1'b0;
    updatePC    = 1'b0;
    jump        = 1'b0;
    offset      = 12'h000;
    halted      = 1'b0;
    case (r_state)
      ST_IDLE: w_next = ST_REQ;
      ST_REQ: begin
        // PC has already been updated at the previous UPD edge, so the
        // address issued here is never stale.
        mem_req  = 1'b1;
        mem_addr = PC;
        if (mem_ready) w_next = ST_HOLD;
      end
      ST_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ack) begin
`ifdef HALT_DETECT_EN
          w_next = w_is_halt ? ST_HALT : ST_UPD;
`else
          w_next = ST_UPD;
`endif
        end
      end
      ST_UPD: begin
        // cond feeds jump only here, so its value during HOLD is irrelevant.
        updatePC = 1'b1;
        jump     = w_is_jump;
        offset   = w_offset;
        w_next   = ST_REQ;
      end
`ifdef HALT_DETECT_EN
      ST_HALT: halted = 1'b1;
`endif
      default: w_next = ST_IDLE;
    endcase
  end

endmodule
